hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
// - Sequencer for Pipeline_Registers: generates stall_i, stall_all_i, flush_i.
// - Load-use stall on ID vs EX; branch flush of IF/ID; whole-pipe freeze while a data-memory
//   access in MEM waits for its ack. Sits in the CPU top between decode, DM handshake and regs.
// PARAMETERS
// - MEMREAD_BIT  4   bit index of MemRead in 7-bit EX control word
// - MAX_WAIT     16  DM wait cycles before sticky timeout error (>=1)
// - CNT_W        32  perf counter width (HAZARD_PERF_CNT_EN only)
// PORTS
// - clk_i          in   1   clock, rising edge
// - rst_i          in   1   asynchronous active-low reset
// - insID_i        in   32  instruction in IF/ID
// - insEX_i        in   32  instruction in ID/EX
// - ctrlEX_i       in   7   control word in ID/EX
// - branch_taken_i in   1   ID-stage branch/jump resolved taken
// - mem_req_i      in   1   instruction in MEM accesses DM (load/store)
// - mem_ack_i      in   1   DM access complete (may be same cycle as start)
// - stall_o        out  1   hold PC and IF/ID -> stall_i
// - stall_all_o    out  1   freeze every pipe reg -> stall_all_i
// - flush_o        out  1   zero IF/ID instruction -> flush_i
// - bubble_o       out  1   ID must drive ctrl_i=0 (equals stall_o)
// - mem_start_o    out  1   one-cycle DM start pulse
// - timeout_o      out  1   sticky: DM wait exceeded MAX_WAIT
// BEHAVIOUR
// - Reset (rst_i=0, async): state=IDLE, wait_cnt=0, timeout_o=0; all combinational outputs
//   evaluate to 0 during reset; counters cleared.
// - Load-use (comb): lu = ctrlEX_i[MEMREAD_BIT] & rdEX!=0 & (rdEX==rs1ID | (useRs2 & rdEX==rs2ID));
//   rdEX=insEX_i[11:7], rs1ID=insID_i[19:15], rs2ID=insID_i[24:20];
//   useRs2 for opcode insID_i[6:0] in {0110011,0100011,1100011}. Exactly one stall cycle.
// - stall_o = bubble_o = lu & ~stall_all_o.
// - flush_o = branch_taken_i & ~stall_o & ~stall_all_o (stall beats flush; branch re-evaluated next cycle).
// - DM FSM, states IDLE, BUSY:
//   IDLE: mem_req_i -> mem_start_o=1; if mem_ack_i same cycle stay IDLE, stall_all_o=0;
//         else stall_all_o=1, go BUSY, wait_cnt<=1.
//   BUSY: mem_start_o=0; stall_all_o=~mem_ack_i; ack -> IDLE, wait_cnt<=0;
//         else wait_cnt<=wait_cnt+1 (saturating); wait_cnt==MAX_WAIT -> timeout_o<=1.
//   Timeout does not abort: pipe stays frozen until ack. timeout_o cleared only by reset.
// - Ack cycle: stall_all_o=0, regs advance on that edge; a new mem_req_i next cycle restarts.
// - mem_ack_i in IDLE without mem_req_i: ignored.
// - Reset mid-BUSY: immediate IDLE, freeze released asynchronously.
// CONFIGURATION
// - HAZARD_PERF_CNT_EN defined: adds outputs lu_cnt_o, flush_cnt_o, memstall_cnt_o [CNT_W-1:0];
//   +1 per cycle stall_o / flush_o / stall_all_o is 1; saturate at all-ones; reset to 0.
// - Undefined: those ports and registers absent; all other behaviour identical.
// TESTING
// - lw x5 in EX (ctrlEX_i[4]=1), add x6,x5,x7 in ID -> stall_o=bubble_o=1 one cycle, then 0.
// - lw x0 in EX, ID reads x0 -> stall_o=0; lw x5, ID=sw x5 rs2-only -> stall_o=1.
// - lu=1 with branch_taken_i=1 -> flush_o=0; next cycle lu=0, taken=1 -> flush_o=1.
// - mem_req_i=1, ack after 3 cycles -> mem_start_o pulse 1 cycle, stall_all_o=1 for 3, 0 on ack.
// - mem_req_i=1, mem_ack_i=1 same cycle -> stall_all_o=0, state stays IDLE.
// - ack withheld 20 cycles, MAX_WAIT=16 -> timeout_o=1 after 16th wait, sticky past ack;
//   rst_i low mid-wait -> stall_all_o=0 immediately.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl                                                          |
// | Load-use stall, branch flush and data-memory freeze sequencer for the      |
// | pipeline registers. Optional perf counters: HAZARD_PERF_CNT_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_stall_ctrl #(
   parameter int MEMREAD_BIT = 4,
   parameter int MAX_WAIT    = 16,
   parameter int CNT_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       insID_i,
   input  logic [31:0]       insEX_i,
   input  logic [6:0]        ctrlEX_i,
   input  logic              branch_taken_i,
   input  logic              mem_req_i,
   input  logic              mem_ack_i,
   output logic              stall_o,
   output logic              stall_all_o,
   output logic              flush_o,
   output logic              bubble_o,
   output logic              mem_start_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0]  lu_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o,
   output logic [CNT_W-1:0]  memstall_cnt_o,
`endif
   output logic              timeout_o
);

   localparam int c_wait_w = $clog2(MAX_WAIT + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [c_wait_w-1:0] wait_cnt_q, wait_cnt_d;
   logic                timeout_q, timeout_d;

   logic [4:0] rd_ex, rs1_id, rs2_id;
   logic       use_rs2, lu;
   logic       stall_all, mem_start;

   logic unused_ok;
   assign unused_ok = ^{insID_i, insEX_i, ctrlEX_i};

   always_comb begin
      rd_ex   = insEX_i[11:7];
      rs1_id  = insID_i[19:15];
      rs2_id  = insID_i[24:20];
      use_rs2 = (insID_i[6:0] == 7'b0110011) |
                (insID_i[6:0] == 7'b0100011) |
                (insID_i[6:0] == 7'b1100011);
      lu      = ctrlEX_i[MEMREAD_BIT] & (rd_ex != 5'd0) &
                ((rd_ex == rs1_id) | (use_rs2 & (rd_ex == rs2_id)));
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      mem_start  = 1'b0;
      stall_all  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_req_i) begin
               mem_start = 1'b1;
               if (!mem_ack_i) begin
                  stall_all  = 1'b1;
                  state_d    = ST_BUSY;
                  wait_cnt_d = c_wait_w'(1);
               end
            end
         end
         ST_BUSY: begin
            stall_all = ~mem_ack_i;
            if (mem_ack_i) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else begin
               // Counter parks at MAX_WAIT; the timeout flag carries the rest.
               if (wait_cnt_q != c_wait_w'(MAX_WAIT)) begin
                  wait_cnt_d = wait_cnt_q + c_wait_w'(1);
               end
               if (wait_cnt_q == c_wait_w'(MAX_WAIT)) begin
                  timeout_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Combinational outputs are forced low while reset is asserted.
   assign stall_all_o = stall_all & rst_i;
   assign mem_start_o = mem_start & rst_i;
   assign stall_o     = lu & ~stall_all & rst_i;
   assign bubble_o    = stall_o;
   assign flush_o     = branch_taken_i & ~stall_o & ~stall_all_o & rst_i;
   assign timeout_o   = timeout_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] memstall_cnt_q, memstall_cnt_d;

   always_comb begin
      lu_cnt_d       = lu_cnt_q + {{(CNT_W-1){1'b0}}, (stall_o & ~(&lu_cnt_q))};
      flush_cnt_d    = flush_cnt_q + {{(CNT_W-1){1'b0}}, (flush_o & ~(&flush_cnt_q))};
      memstall_cnt_d = memstall_cnt_q +
                       {{(CNT_W-1){1'b0}}, (stall_all_o & ~(&memstall_cnt_q))};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lu_cnt_q       <= '0;
         flush_cnt_q    <= '0;
         memstall_cnt_q <= '0;
      end else begin
         lu_cnt_q       <= lu_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
         memstall_cnt_q <= memstall_cnt_d;
      end
   end

   assign lu_cnt_o       = lu_cnt_q;
   assign flush_cnt_o    = flush_cnt_q;
   assign memstall_cnt_o = memstall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_stall_ctrl                                                       |
// | Directed and random stimulus against a behavioural hazard/DM-wait model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_stall_ctrl;

   localparam int MAX_WAIT = 16;
   localparam int CNT_W    = 32;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] insID_i, insEX_i;
   logic [6:0]  ctrlEX_i;
   logic        branch_taken_i, mem_req_i, mem_ack_i;
   logic        stall_o, stall_all_o, flush_o, bubble_o, mem_start_o, timeout_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] lu_cnt_o, flush_cnt_o, memstall_cnt_o;
`endif

   hazard_stall_ctrl #(
      .MEMREAD_BIT(4),
      .MAX_WAIT   (MAX_WAIT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .insID_i       (insID_i),
      .insEX_i       (insEX_i),
      .ctrlEX_i      (ctrlEX_i),
      .branch_taken_i(branch_taken_i),
      .mem_req_i     (mem_req_i),
      .mem_ack_i     (mem_ack_i),
      .stall_o       (stall_o),
      .stall_all_o   (stall_all_o),
      .flush_o       (flush_o),
      .bubble_o      (bubble_o),
      .mem_start_o   (mem_start_o),
`ifdef HAZARD_PERF_CNT_EN
      .lu_cnt_o      (lu_cnt_o),
      .flush_cnt_o   (flush_cnt_o),
      .memstall_cnt_o(memstall_cnt_o),
`endif
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: is an access outstanding, how many un-acked waits so far.
   bit m_busy;
   int m_waits;
   bit m_timeout;
   longint m_lu_cnt, m_flush_cnt, m_ms_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input int rd, rs1, rs2);
      return {7'd0, rs2[4:0], rs1[4:0], 3'd0, rd[4:0], opc};
   endfunction

   function automatic bit ref_lu(input logic [31:0] id, ex, input logic [6:0] ctl);
      int  rd, r1, r2;
      bit  two;
      rd  = int'(ex[11:7]);
      r1  = int'(id[19:15]);
      r2  = int'(id[24:20]);
      two = (id[6:0] == 7'b0110011) || (id[6:0] == 7'b0100011) || (id[6:0] == 7'b1100011);
      return ctl[4] && rd != 0 && (rd == r1 || (two && rd == r2));
   endfunction

   task automatic model_reset();
      m_busy = 0; m_waits = 0; m_timeout = 0;
      m_lu_cnt = 0; m_flush_cnt = 0; m_ms_cnt = 0;
   endtask

   // One cycle: drive at negedge, check just before posedge, advance the model.
   task automatic step(input logic [31:0] id, ex, input logic [6:0] ctl,
                       input bit br, req, ack);
      bit e_sa, e_st, e_fl, e_ms;
      insID_i = id; insEX_i = ex; ctrlEX_i = ctl;
      branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
      #3;
      e_sa = m_busy ? !ack : (req && !ack);
      e_ms = !m_busy && req;
      e_st = ref_lu(id, ex, ctl) && !e_sa;
      e_fl = br && !e_st && !e_sa;
      check("stall",     32'(stall_o),     32'(e_st));
      check("bubble",    32'(bubble_o),    32'(e_st));
      check("stall_all", 32'(stall_all_o), 32'(e_sa));
      check("flush",     32'(flush_o),     32'(e_fl));
      check("mem_start", 32'(mem_start_o), 32'(e_ms));
      check("timeout",   32'(timeout_o),   32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
      check("lu_cnt",       lu_cnt_o,       32'(m_lu_cnt));
      check("flush_cnt",    flush_cnt_o,    32'(m_flush_cnt));
      check("memstall_cnt", memstall_cnt_o, 32'(m_ms_cnt));
`endif
      @(posedge clk_i);
      m_lu_cnt    += longint'(e_st);
      m_flush_cnt += longint'(e_fl);
      m_ms_cnt    += longint'(e_sa);
      if (m_busy) begin
         if (ack) begin
            m_busy = 0; m_waits = 0;
         end else begin
            m_waits++;
            if (m_waits >= MAX_WAIT) m_timeout = 1;
         end
      end else if (req && !ack) begin
         m_busy = 1; m_waits = 0;
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_I  = 7'b0010011;

   function automatic logic [31:0] rand_ins();
      logic [6:0] ops [5];
      ops = '{OP_R, OP_S, OP_B, OP_LD, OP_I};
      return mk(ops[$urandom_range(0, 4)], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
   endfunction

   logic [31:0] lw5, add6, nxt;

   initial begin
      rst_i = 1'b0;
      insID_i = '0; insEX_i = '0; ctrlEX_i = '0;
      branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
      model_reset();
      @(negedge clk_i);
      // Outputs held low in reset even with hazards and a request present.
      insEX_i = mk(OP_LD, 5, 1, 0); insID_i = mk(OP_R, 6, 5, 7); ctrlEX_i = 7'h10;
      branch_taken_i = 1'b1; mem_req_i = 1'b1;
      #2;
      check("rst_stall",     32'(stall_o),     32'd0);
      check("rst_stall_all", 32'(stall_all_o), 32'd0);
      check("rst_flush",     32'(flush_o),     32'd0);
      check("rst_start",     32'(mem_start_o), 32'd0);
      check("rst_timeout",   32'(timeout_o),   32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      lw5  = mk(OP_LD, 5, 1, 0);
      add6 = mk(OP_R, 6, 5, 7);
      nxt  = mk(OP_I, 8, 9, 0);
      // Load-use: one stall, then the bubble leaves EX.
      step(add6, lw5, 7'h10, 0, 0, 0);
      step(add6, add6, 7'h00, 0, 0, 0);
      // x0 destination never stalls; store uses rs2.
      step(mk(OP_R, 6, 0, 0), mk(OP_LD, 0, 1, 0), 7'h10, 0, 0, 0);
      step(mk(OP_S, 0, 1, 5), lw5, 7'h10, 0, 0, 0);
      step(mk(OP_I, 6, 1, 5), lw5, 7'h10, 0, 0, 0);
      // Stall beats flush, branch honoured next cycle.
      step(add6, lw5, 7'h10, 1, 0, 0);
      step(add6, add6, 7'h00, 1, 0, 0);
      // DM access acked after 3 cycles.
      step(nxt, nxt, 7'h00, 0, 1, 0);
      step(nxt, nxt, 7'h00, 0, 0, 0);
      step(nxt, nxt, 7'h00, 1, 0, 0);
      step(nxt, nxt, 7'h00, 0, 0, 1);
      // Same-cycle ack, then a stray ack without request.
      step(nxt, nxt, 7'h00, 0, 1, 1);
      step(nxt, nxt, 7'h00, 0, 0, 1);
      step(add6, lw5, 7'h10, 0, 1, 0);
      step(add6, lw5, 7'h10, 0, 1, 1);

      for (int i = 0; i < 400; i++) begin
         step(rand_ins(), rand_ins(), 7'($urandom), 1'($urandom),
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
      end

      // Withheld ack: timeout after MAX_WAIT waits and sticky past the ack.
      do_reset();
      step(nxt, nxt, 7'h00, 0, 1, 0);
      for (int i = 0; i < 20; i++) step(nxt, nxt, 7'h00, 0, 0, 0);
      step(nxt, nxt, 7'h00, 0, 0, 1);
      step(nxt, nxt, 7'h00, 0, 0, 0);
      step(nxt, nxt, 7'h00, 0, 0, 0);
      check("timeout_sticky", 32'(timeout_o), 32'd1);

      // Reset mid-wait releases the freeze without waiting for a clock.
      do_reset();
      step(nxt, nxt, 7'h00, 0, 1, 0);
      for (int i = 0; i < 17; i++) step(nxt, nxt, 7'h00, 0, 0, 0);
      check("pre_rst_freeze", 32'(stall_all_o), 32'd1);
      #2;
      rst_i = 1'b0;
      #1;
      check("async_rst_stall_all", 32'(stall_all_o), 32'd0);
      check("async_rst_timeout",   32'(timeout_o),   32'd0);
      check("async_rst_start",     32'(mem_start_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      step(nxt, nxt, 7'h00, 0, 0, 0);
      step(nxt, nxt, 7'h00, 0, 1, 0);
      step(nxt, nxt, 7'h00, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
